fb_port_arbiter: RTL

//  Shares the single-port 640x480x12b framebuffer RAM between three requesters:
//  - VGA scan-out reader (address_vga/data path of the VGA controller)
//  - pixel writer (drawing engine)
//  - host read port

---
 rtl/fb_port_arbiter_if.sv | 49 ++++
 rtl/fb_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter_if
//   Bundles the requester-side and RAM-side signals of the framebuffer port
//   arbiter so they travel as one port.
//
//   Scan-out : sc_req, sc_addr -> sc_rdata, sc_rvalid
//   Writer   : wr_valid, wr_addr, wr_data -> wr_ready
//   Host     : hr_req, hr_addr -> hr_ack, hr_rdata
//   RAM      : ram_addr, ram_wdata, ram_we -> ram_rdata
//   Status   : oob_cnt (saturating out-of-range access count)
//
//   slave  : the arbiter itself
//   master : the surrounding requesters and RAM model
// ---------------------------------------------------------------------------
interface fb_port_arbiter_if;
    logic        sc_req;
    logic [18:0] sc_addr;
    logic [11:0] sc_rdata;
    logic        sc_rvalid;

    logic        wr_valid;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;

    logic        hr_req;
    logic [18:0] hr_addr;
    logic        hr_ack;
    logic [11:0] hr_rdata;

    logic [18:0] ram_addr;
    logic [11:0] ram_wdata;
    logic        ram_we;
    logic [11:0] ram_rdata;

    logic [7:0]  oob_cnt;

    modport slave (
        input  sc_req, sc_addr, wr_valid, wr_addr, wr_data, hr_req, hr_addr, ram_rdata,
        output sc_rdata, sc_rvalid, wr_ready, hr_ack, hr_rdata,
               ram_addr, ram_wdata, ram_we, oob_cnt
    );

    modport master (
        output sc_req, sc_addr, wr_valid, wr_addr, wr_data, hr_req, hr_addr, ram_rdata,
        input  sc_rdata, sc_rvalid, wr_ready, hr_ack, hr_rdata,
               ram_addr, ram_wdata, ram_we, oob_cnt
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter
//   Shares the single-port 640x480x12b framebuffer RAM between the VGA
//   scan-out reader, the pixel writer and a host read port. Scan-out has
//   absolute priority; writer and host alternate round-robin on the rest.
//
//   Ports:
//     clk_vga  pixel clock, all logic on the rising edge
//     rst_n    asynchronous active-low reset
//     bus      fb_port_arbiter_if.slave (requesters, RAM side, oob_cnt)
//
//   Optional feature: define FB_WBUF_EN to place a WBUF_DEPTH-entry FIFO in
//   front of the writer. Without it the writer handshake is direct.
// ---------------------------------------------------------------------------
module fb_port_arbiter #(
    parameter int Wight      = 640,
    parameter int Height     = 480,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    fb_port_arbiter_if.slave  bus
);

    localparam logic [18:0] FB_SIZE = 19'(Wight * Height);

    if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("WBUF_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {G_IDLE, G_SCAN, G_WR, G_HOST} grant_e;
    typedef enum logic {LAST_WR, LAST_HOST} last_e;

    grant_e      grant;
    last_e       last_q, last_d;
    logic [18:0] addr_q, ram_addr_d;
    logic [11:0] ram_wdata_d;
    logic        ram_we_d;
    logic        sc_rvalid_q, hr_pend_q, hr_oob_q;
    logic [7:0]  oob_q;

    // Writer-side request as seen by the grant logic (direct or FIFO head).
    logic        wr_req;
    logic [18:0] wr_req_addr;
    logic [11:0] wr_req_data;
    logic        wr_oob, hr_oob, host_elig;

`ifdef FB_WBUF_EN
    localparam int PW = $clog2(WBUF_DEPTH);

    logic [18:0]   fifo_addr [WBUF_DEPTH];
    logic [11:0]   fifo_data [WBUF_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          full, push, pop;

    // Full comes from the count register, so a pop in the same cycle never
    // frees a slot early; an entry pushed into an empty FIFO is only visible
    // to the grant logic the following cycle.
    assign full        = (count == (PW+1)'(WBUF_DEPTH));
    assign push        = bus.wr_valid & ~full;
    assign pop         = (grant == G_WR);
    assign wr_req      = (count != '0);
    assign wr_req_addr = fifo_addr[rd_ptr];
    assign wr_req_data = fifo_data[rd_ptr];
    assign bus.wr_ready = rst_n & ~full;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count alone define validity,
    // and leaving data arrays out of reset lets them map onto plain RAM/flops.
    always_ff @(posedge clk_vga) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end
`else
    assign wr_req       = bus.wr_valid;
    assign wr_req_addr  = bus.wr_addr;
    assign wr_req_data  = bus.wr_data;
    assign bus.wr_ready = (grant == G_WR);
`endif

    assign wr_oob    = (wr_req_addr >= FB_SIZE);
    assign hr_oob    = (bus.hr_addr >= FB_SIZE);
    assign host_elig = bus.hr_req & ~hr_pend_q;

    // Grant selection. rst_n forces IDLE so every combinational output is
    // quiet while reset is held, even with requests active.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        grant  = G_IDLE;
        last_d = last_q;
        if (!rst_n) begin
            grant = G_IDLE;
        end else if (bus.sc_req) begin
            grant = G_SCAN;
        end else if (wr_req && host_elig) begin
            grant = (last_q == LAST_WR) ? G_HOST : G_WR;
        end else if (wr_req) begin
            grant = G_WR;
        end else if (host_elig) begin
            grant = G_HOST;
        end
        if (grant == G_WR)   last_d = LAST_WR;
        if (grant == G_HOST) last_d = LAST_HOST;
    end

    // RAM port mux. Address holds whenever no RAM cycle is used, including
    // out-of-range writer/host accesses.
    always_comb begin
        ram_addr_d  = addr_q;
        ram_wdata_d = '0;
        ram_we_d    = 1'b0;
        case (grant)
            G_SCAN: ram_addr_d = bus.sc_addr;
            G_WR: begin
                if (!wr_oob) begin
                    ram_addr_d  = wr_req_addr;
                    ram_wdata_d = wr_req_data;
                    ram_we_d    = 1'b1;
                end
            end
            G_HOST: begin
                if (!hr_oob) ram_addr_d = bus.hr_addr;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= LAST_HOST;
            addr_q      <= '0;
            sc_rvalid_q <= 1'b0;
            hr_pend_q   <= 1'b0;
            hr_oob_q    <= 1'b0;
            oob_q       <= '0;
        end else begin
            last_q      <= last_d;
            addr_q      <= ram_addr_d;
            sc_rvalid_q <= bus.sc_req;
            hr_pend_q   <= (grant == G_HOST);
            hr_oob_q    <= hr_oob;
            if (((grant == G_WR && wr_oob) || (grant == G_HOST && hr_oob)) && oob_q != 8'hFF)
                oob_q <= oob_q + 8'd1;
        end
    end

    assign bus.ram_addr  = ram_addr_d;
    assign bus.ram_wdata = ram_wdata_d;
    assign bus.ram_we    = ram_we_d;
    assign bus.sc_rdata  = bus.ram_rdata;
    assign bus.sc_rvalid = sc_rvalid_q;
    assign bus.hr_ack    = hr_pend_q;
    assign bus.hr_rdata  = (hr_pend_q && !hr_oob_q) ? bus.ram_rdata : 12'h000;
    assign bus.oob_cnt   = oob_q;

endmodule
